// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, bus addresses and oversample constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [15:0] START_SEND = 16'h0110;
  localparam logic [15:0] LOAD_DATA  = 16'h0111;
  localparam logic [15:0] RX_READ    = 16'h0112;

  localparam int unsigned OS_RATE = 16;
  localparam logic [3:0]  OS_MID  = 4'd7;
  localparam logic [3:0]  OS_LAST = 4'd15;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - CPU-side bus of the UART receiver
interface uart_rx_if;
  logic [15:0] addr;
  logic        ack;
  logic        irq;
  logic [7:0]  rxdata_out;
  logic        frame_err;
  logic        overrun;

  modport master (
    output addr, ack,
    input  irq, rxdata_out, frame_err, overrun
  );

  modport slave (
    input  addr, ack,
    output irq, rxdata_out, frame_err, overrun
  );
endinterface

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - oversample tick generator, one-clk pulse every OS_DIV clks
module uart_os_tick #(
  parameter int unsigned OS_DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic os_tick
);

  logic [15:0] cnt;

  // Cycles 0, OS_DIV-1 .. 1 form one period; the tick lands OS_DIV clks after clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= 16'(OS_DIV - 1);
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  assign os_tick = (cnt == 16'd1);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and interrupt-style handoff
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OS_DIV = 651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxin,
  uart_rx_if.slave   bus,
  output logic [1:0] state
);

  rx_state_t  st;
  logic [1:0] rx_sync;
  logic       rx_s;
  logic       rx_s_d;
  logic [3:0] sctr;
  logic [2:0] bctr;
  logic [7:0] shreg;
  logic [7:0] rxdata_r;
  logic       irq_r;
  logic       frame_err_r;
  logic       overrun_r;
  logic       start_edge;
  logic       os_tick;
  logic       clear;

  assign rx_s       = rx_sync[1];
  assign start_edge = (st == IDLE) && rx_s_d && !rx_s;
  assign clear      = bus.ack || (bus.addr == RX_READ);

  uart_os_tick #(.OS_DIV(OS_DIV)) u_os_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_edge),
    .os_tick (os_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync     <= 2'b11;
      rx_s_d      <= 1'b1;
      st          <= IDLE;
      sctr        <= '0;
      bctr        <= '0;
      shreg       <= '0;
      rxdata_r    <= '0;
      irq_r       <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rxin};
      rx_s_d  <= rx_s;
      if (clear) begin
        irq_r     <= 1'b0;
        overrun_r <= 1'b0;
      end
      case (st)
        IDLE: begin
          if (start_edge) begin
            st   <= START;
            sctr <= '0;
          end
        end
        START: begin
          if (os_tick) begin
            if (sctr == OS_MID) begin
              if (!rx_s) begin
                st   <= DATA;
                sctr <= '0;
                bctr <= '0;
              end else begin
                st <= IDLE;
              end
            end else begin
              sctr <= sctr + 4'd1;
            end
          end
        end
        DATA: begin
          if (os_tick) begin
            sctr <= sctr + 4'd1;
            if (sctr == OS_LAST) begin
              shreg <= {rx_s, shreg[7:1]};
              if (bctr == 3'd7) st <= STOP;
              else              bctr <= bctr + 3'd1;
            end
          end
        end
        STOP: begin
          if (os_tick) begin
            sctr <= sctr + 4'd1;
            if (sctr == OS_LAST) begin
              // A completing byte overrides a same-cycle clear of irq.
              rxdata_r    <= shreg;
              frame_err_r <= ~rx_s;
              irq_r       <= 1'b1;
              overrun_r   <= clear ? 1'b0 : (overrun_r | irq_r);
              st          <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.irq        = irq_r;
  assign bus.rxdata_out = rxdata_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.overrun    = overrun_r;
  assign state          = st;

endmodule
